// File: rtl/button_conditioner.sv
// Two-channel conditioner: 2-flop synchronizer plus counter debouncer per channel,
// producing clean levels and one-cycle rising-edge pulses for the downstream FSM.

module button_conditioner_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic lvl_o,
  output logic rise_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1_q, s2_q;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lvl_q, lvl_d;
  logic             rise_q, rise_d;

  // Raw input is asynchronous; s1 may go metastable and is only observed through s2.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments model every flop updating together on the edge;
    // blocking here would let s2 see this cycle's s1 and collapse the synchronizer.
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    rise_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s2_q != lvl_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            lvl_d  = s2_q;
            rise_d = s2_q;
            cnt_d  = '0;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      COUNT: begin
        if (s2_q == lvl_q) begin
          // Glitch ended early; drop the partial count so interruptions never accumulate.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          lvl_d   = s2_q;
          rise_d  = s2_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      rise_q  <= rise_d;
    end
  end

  assign lvl_o  = lvl_q;
  assign rise_o = rise_q;

endmodule

module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .reset (reset),
    .raw_i (btn_a_raw),
    .lvl_o (a),
    .rise_o(a_rise)
  );

  button_conditioner_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .reset (reset),
    .raw_i (btn_b_raw),
    .lvl_o (b),
    .rise_o(b_rise)
  );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at DEBOUNCE_CYCLES = 4: expected levels and
// pulses are hand-derived edge by edge (commit lands 6 edges after a raw change).

module tb_button_conditioner;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_a_raw = 1'b0;
  logic btn_b_raw = 1'b0;
  logic a, b, a_rise, b_rise;

  int passed = 0;
  int total  = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_a_raw(btn_a_raw),
    .btn_b_raw(btn_b_raw),
    .a        (a),
    .b        (b),
    .a_rise   (a_rise),
    .b_rise   (b_rise)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp_lvl, exp_rise;
    reset = 1'b0;
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    for (int i = 0; i < 3; i++) step();
    total++; if (a !== 1'b0)      $display("FAIL reset_a: got %b want 0", a);           else passed++;
    total++; if (b !== 1'b0)      $display("FAIL reset_b: got %b want 0", b);           else passed++;
    total++; if (a_rise !== 1'b0) $display("FAIL reset_a_rise: got %b want 0", a_rise); else passed++;
    total++; if (b_rise !== 1'b0) $display("FAIL reset_b_rise: got %b want 0", b_rise); else passed++;
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      total++; if (a !== exp_lvl)       $display("FAIL reset_release_a edge%0d: got %b want %b", i, a, exp_lvl);           else passed++;
      total++; if (a_rise !== exp_rise) $display("FAIL reset_release_a_rise edge%0d: got %b want %b", i, a_rise, exp_rise); else passed++;
      total++; if (b !== exp_lvl)       $display("FAIL reset_release_b edge%0d: got %b want %b", i, b, exp_lvl);           else passed++;
      total++; if (b_rise !== exp_rise) $display("FAIL reset_release_b_rise edge%0d: got %b want %b", i, b_rise, exp_rise); else passed++;
    end
  endtask

  // Starts with a = b = 1; drops A, then B, checking release timing and no pulse.
  task automatic test_release();
    logic exp_lvl;
    btn_a_raw = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_lvl = (i < 6);
      total++; if (a !== exp_lvl)  $display("FAIL release_a edge%0d: got %b want %b", i, a, exp_lvl);  else passed++;
      total++; if (a_rise !== 1'b0) $display("FAIL release_a_rise edge%0d: got %b want 0", i, a_rise); else passed++;
      total++; if (b !== 1'b1)     $display("FAIL release_b_hold edge%0d: got %b want 1", i, b);       else passed++;
    end
    btn_b_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++; if (b !== 1'b0)      $display("FAIL release_b: got %b want 0", b);           else passed++;
    total++; if (b_rise !== 1'b0) $display("FAIL release_b_rise: got %b want 0", b_rise); else passed++;
  endtask

  // Raw change is applied before E0; the loop index is the edge number.
  task automatic test_clean_press();
    logic exp_lvl, exp_rise;
    btn_a_raw = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      exp_lvl  = (i >= 5);
      exp_rise = (i == 5);
      total++; if (a !== exp_lvl)       $display("FAIL press_a E%0d: got %b want %b", i, a, exp_lvl);           else passed++;
      total++; if (a_rise !== exp_rise) $display("FAIL press_a_rise E%0d: got %b want %b", i, a_rise, exp_rise); else passed++;
    end
    btn_a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    total++; if (a !== 1'b0) $display("FAIL press_release_a: got %b want 0", a); else passed++;
  endtask

  // Three high samples is one short of the debounce window.
  task automatic test_bounce();
    logic exp_lvl, exp_rise;
    btn_a_raw = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (i == 2) btn_a_raw = 1'b0;
      total++; if (a !== 1'b0)      $display("FAIL bounce_a step%0d: got %b want 0", i, a);           else passed++;
      total++; if (a_rise !== 1'b0) $display("FAIL bounce_a_rise step%0d: got %b want 0", i, a_rise); else passed++;
    end
    btn_a_raw = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      exp_lvl  = (i >= 5);
      exp_rise = (i == 5);
      total++; if (a !== exp_lvl)       $display("FAIL bounce_hold_a E%0d: got %b want %b", i, a, exp_lvl);           else passed++;
      total++; if (a_rise !== exp_rise) $display("FAIL bounce_hold_a_rise E%0d: got %b want %b", i, a_rise, exp_rise); else passed++;
    end
    btn_a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_simultaneous();
    logic exp_lvl, exp_rise;
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      step();
      exp_lvl  = (i >= 5);
      exp_rise = (i == 5);
      total++; if (a !== exp_lvl)       $display("FAIL simul_a E%0d: got %b want %b", i, a, exp_lvl);           else passed++;
      total++; if (b !== exp_lvl)       $display("FAIL simul_b E%0d: got %b want %b", i, b, exp_lvl);           else passed++;
      total++; if (a_rise !== exp_rise) $display("FAIL simul_a_rise E%0d: got %b want %b", i, a_rise, exp_rise); else passed++;
      total++; if (b_rise !== exp_rise) $display("FAIL simul_b_rise E%0d: got %b want %b", i, b_rise, exp_rise); else passed++;
    end
    btn_a_raw = 1'b0;
    btn_b_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    // B bounces (sampled high at E0, E1 only) while A debounces normally.
    btn_a_raw = 1'b1;
    btn_b_raw = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      step();
      if (i == 1) btn_b_raw = 1'b0;
      exp_lvl  = (i >= 5);
      exp_rise = (i == 5);
      total++; if (a !== exp_lvl)       $display("FAIL indep_a E%0d: got %b want %b", i, a, exp_lvl);           else passed++;
      total++; if (a_rise !== exp_rise) $display("FAIL indep_a_rise E%0d: got %b want %b", i, a_rise, exp_rise); else passed++;
      total++; if (b !== 1'b0)          $display("FAIL indep_b E%0d: got %b want 0", i, b);                     else passed++;
      total++; if (b_rise !== 1'b0)     $display("FAIL indep_b_rise E%0d: got %b want 0", i, b_rise);           else passed++;
    end
    btn_a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic test_reset_mid_count();
    logic exp_lvl, exp_rise;
    btn_b_raw = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    total++; if (b !== 1'b0)      $display("FAIL midreset_b: got %b want 0", b);           else passed++;
    total++; if (b_rise !== 1'b0) $display("FAIL midreset_b_rise: got %b want 0", b_rise); else passed++;
    reset = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      exp_lvl  = (i >= 6);
      exp_rise = (i == 6);
      total++; if (b !== exp_lvl)       $display("FAIL midreset_release_b edge%0d: got %b want %b", i, b, exp_lvl);           else passed++;
      total++; if (b_rise !== exp_rise) $display("FAIL midreset_release_b_rise edge%0d: got %b want %b", i, b_rise, exp_rise); else passed++;
      total++; if (a !== 1'b0)          $display("FAIL midreset_a edge%0d: got %b want 0", i, a);                             else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
